// File: rtl/smallseg_rule_table.sv
// Rule table: block-RAM entry storage with a flop occupancy vector, a fully pipelined
// 2-cycle lookup path and a two-state update engine (insert / delete / modify).
module smallseg_rule_table #(
  parameter int ENTRY_W = 171,
  parameter int DEPTH   = 1739,
  parameter int ADDR_W  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lkp_valid,
  input  logic [ADDR_W-1:0]  lkp_addr,
  output logic               res_valid,
  output logic               res_hit,
  output logic [ENTRY_W-1:0] res_data,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [1:0]         upd_op,
  input  logic [ADDR_W-1:0]  upd_addr,
  input  logic [ENTRY_W-1:0] upd_data,
  output logic               upd_done,
  output logic               upd_err,
  output logic [ADDR_W:0]    entry_count
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;
  localparam logic [1:0] OP_MOD = 2'b11;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t state, next_state;

  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ENTRY_W-1:0] data_q;
  logic [DEPTH-1:0]   occ;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] ram_q;

  logic addr_ok, cur_occ, op_err, exec_ok, wr_mem;

  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic               s1_ok, byp;
  logic               s2_valid, s2_hit, s2_use_wd;
  logic [ENTRY_W-1:0] s2_wdata;

  always_comb begin
    addr_ok = ({1'b0, addr_q} < DEPTH_C);
    cur_occ = addr_ok & occ[addr_q];
    op_err  = 1'b1;
    case (op_q)
      OP_INS:  op_err = cur_occ;
      OP_DEL:  op_err = ~cur_occ;
      OP_MOD:  op_err = ~cur_occ;
      default: op_err = 1'b1;
    endcase
    op_err  = op_err | ~addr_ok;
    exec_ok = (state == EXEC) && !op_err;
    wr_mem  = exec_ok && (op_q == OP_INS || op_q == OP_MOD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (upd_valid) next_state = EXEC;
      EXEC:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    upd_ready = (state == IDLE);
    upd_done  = (state == EXEC);
    upd_err   = (state == EXEC) && op_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 2'b00;
      addr_q <= '0;
      data_q <= '0;
    end else if (state == IDLE && upd_valid) begin
      op_q   <= upd_op;
      addr_q <= upd_addr;
      data_q <= upd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ         <= '0;
      entry_count <= '0;
    end else if (exec_ok) begin
      if (op_q == OP_INS) begin
        occ[addr_q] <= 1'b1;
        entry_count <= entry_count + ONE_C;
      end else if (op_q == OP_DEL) begin
        occ[addr_q] <= 1'b0;
        entry_count <= entry_count - ONE_C;
      end
    end
  end

  // Read-first RAM; a same-edge write to the address being read is bypassed below.
  always_ff @(posedge clk) begin
    if (wr_mem) mem[addr_q] <= data_q;
    ram_q <= mem[s1_addr];
  end

  always_comb begin
    s1_ok = ({1'b0, s1_addr} < DEPTH_C);
    byp   = exec_ok && (addr_q == s1_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s2_valid  <= 1'b0;
      s2_hit    <= 1'b0;
      s2_use_wd <= 1'b0;
      s2_wdata  <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_data  <= '0;
    end else begin
      s1_valid  <= lkp_valid;
      s1_addr   <= lkp_addr;
      s2_valid  <= s1_valid;
      s2_hit    <= s1_valid && s1_ok && (byp ? (op_q != OP_DEL) : occ[s1_addr]);
      s2_use_wd <= byp;
      s2_wdata  <= data_q;
      res_valid <= s2_valid;
      res_hit   <= s2_valid && s2_hit;
      res_data  <= (s2_valid && s2_hit) ? (s2_use_wd ? s2_wdata : ram_q) : '0;
    end
  end

endmodule

// File: tb/tb_smallseg_rule_table.sv
// Directed self-checking bench for smallseg_rule_table: reset, insert/delete/modify,
// write-first lookup ordering, back-to-back updates, lookup streaming and reset mid-update.
module tb_smallseg_rule_table;

  localparam int EW = 171;
  localparam int AW = 11;
  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;
  localparam logic [1:0] OP_MOD = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lkp_valid;
  logic [AW-1:0] lkp_addr;
  logic          res_valid, res_hit;
  logic [EW-1:0] res_data;
  logic          upd_valid, upd_ready;
  logic [1:0]    upd_op;
  logic [AW-1:0] upd_addr;
  logic [EW-1:0] upd_data;
  logic          upd_done, upd_err;
  logic [AW:0]   entry_count;

  int checks = 0;
  int passes = 0;

  smallseg_rule_table dut (
    .clk(clk), .rst_n(rst_n),
    .lkp_valid(lkp_valid), .lkp_addr(lkp_addr),
    .res_valid(res_valid), .res_hit(res_hit), .res_data(res_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
    .upd_addr(upd_addr), .upd_data(upd_data),
    .upd_done(upd_done), .upd_err(upd_err), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single lookup; early is res_valid one cycle before the expected result cycle.
  task automatic do_lookup(input logic [AW-1:0] a, output logic early, output logic v,
                           output logic h, output logic [EW-1:0] d);
    @(negedge clk); lkp_valid = 1'b1; lkp_addr = a;
    @(negedge clk); lkp_valid = 1'b0;
    @(negedge clk); early = res_valid;
    @(negedge clk); v = res_valid; h = res_hit; d = res_data;
  endtask

  task automatic do_update(input logic [1:0] op, input logic [AW-1:0] a, input logic [EW-1:0] d,
                           output logic got, output logic err);
    got = 1'b0; err = 1'b0;
    @(negedge clk); upd_valid = 1'b1; upd_op = op; upd_addr = a; upd_data = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (upd_done) begin got = 1'b1; err = upd_err; break; end
    end
    upd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic e, v, h; logic [EW-1:0] d;
    @(negedge clk);
    checks++; if (upd_done !== 1'b0 || res_valid !== 1'b0) $display("[TB] FAIL reset_outputs: got done=%b valid=%b expected 0/0", upd_done, res_valid); else passes++;
    checks++; if (entry_count !== '0) $display("[TB] FAIL reset_count: got %0d expected 0", entry_count); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (upd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", upd_ready); else passes++;
    do_lookup(11'd5, e, v, h, d);
    checks++; if (e !== 1'b0 || v !== 1'b1) $display("[TB] FAIL reset_lkp_latency: got early=%b valid=%b expected 0/1", e, v); else passes++;
    checks++; if (h !== 1'b0 || d !== '0) $display("[TB] FAIL reset_lkp_miss: got hit=%b data=%h expected 0/0", h, d); else passes++;
  endtask

  task automatic test_insert;
    logic g, er, e, v, h; logic [EW-1:0] d;
    do_update(OP_INS, 11'd5, EW'(32'h1234), g, er);
    checks++; if (g !== 1'b1 || er !== 1'b0) $display("[TB] FAIL ins_done: got done=%b err=%b expected 1/0", g, er); else passes++;
    checks++; if (entry_count !== 12'd1) $display("[TB] FAIL ins_count: got %0d expected 1", entry_count); else passes++;
    do_lookup(11'd5, e, v, h, d);
    checks++; if (v !== 1'b1 || h !== 1'b1 || d !== EW'(32'h1234)) $display("[TB] FAIL ins_lkp: got v=%b hit=%b data=%h expected 1/1/1234", v, h, d); else passes++;
    do_update(OP_INS, 11'd5, EW'(32'h9999), g, er);
    checks++; if (g !== 1'b1 || er !== 1'b1) $display("[TB] FAIL ins_dup_err: got done=%b err=%b expected 1/1", g, er); else passes++;
    checks++; if (entry_count !== 12'd1) $display("[TB] FAIL ins_dup_count: got %0d expected 1", entry_count); else passes++;
    do_lookup(11'd5, e, v, h, d);
    checks++; if (d !== EW'(32'h1234)) $display("[TB] FAIL ins_dup_data: got %h expected 1234", d); else passes++;
  endtask

  task automatic test_modify_delete;
    logic g, er, e, v, h; logic [EW-1:0] d;
    // Lookup sampled on the handshake edge: the write lands one cycle later (bypass path).
    @(negedge clk); upd_valid = 1'b1; upd_op = OP_MOD; upd_addr = 11'd5; upd_data = EW'(32'h5678);
    lkp_valid = 1'b1; lkp_addr = 11'd5;
    @(negedge clk);
    checks++; if (upd_done !== 1'b1 || upd_err !== 1'b0) $display("[TB] FAIL mod1_done: got done=%b err=%b expected 1/0", upd_done, upd_err); else passes++;
    upd_valid = 1'b0; lkp_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_data !== EW'(32'h5678)) $display("[TB] FAIL mod_bypass: got v=%b hit=%b data=%h expected 1/1/5678", res_valid, res_hit, res_data); else passes++;
    // Lookup sampled on the EXEC edge itself.
    @(negedge clk); upd_valid = 1'b1; upd_op = OP_MOD; upd_addr = 11'd5; upd_data = EW'(32'hABCD);
    @(negedge clk);
    checks++; if (upd_done !== 1'b1 || upd_err !== 1'b0) $display("[TB] FAIL mod2_done: got done=%b err=%b expected 1/0", upd_done, upd_err); else passes++;
    upd_valid = 1'b0; lkp_valid = 1'b1; lkp_addr = 11'd5;
    @(negedge clk); lkp_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_data !== EW'(32'hABCD)) $display("[TB] FAIL mod_exec_edge: got v=%b hit=%b data=%h expected 1/1/abcd", res_valid, res_hit, res_data); else passes++;
    checks++; if (entry_count !== 12'd1) $display("[TB] FAIL mod_count: got %0d expected 1", entry_count); else passes++;
    do_update(OP_DEL, 11'd5, '0, g, er);
    checks++; if (g !== 1'b1 || er !== 1'b0 || entry_count !== 12'd0) $display("[TB] FAIL del: got done=%b err=%b count=%0d expected 1/0/0", g, er, entry_count); else passes++;
    do_lookup(11'd5, e, v, h, d);
    checks++; if (v !== 1'b1 || h !== 1'b0 || d !== '0) $display("[TB] FAIL del_lkp: got v=%b hit=%b data=%h expected 1/0/0", v, h, d); else passes++;
    do_update(OP_DEL, 11'd5, '0, g, er);
    checks++; if (g !== 1'b1 || er !== 1'b1) $display("[TB] FAIL del_empty_err: got done=%b err=%b expected 1/1", g, er); else passes++;
    do_update(OP_MOD, 11'd5, EW'(32'h77), g, er);
    checks++; if (g !== 1'b1 || er !== 1'b1 || entry_count !== 12'd0) $display("[TB] FAIL mod_empty_err: got err=%b count=%0d expected 1/0", er, entry_count); else passes++;
  endtask

  task automatic test_back_to_back;
    logic g, er, e, v, h; logic [EW-1:0] d;
    @(negedge clk); upd_valid = 1'b1; upd_op = OP_INS; upd_addr = 11'd10; upd_data = EW'(32'h10A);
    checks++; if (upd_ready !== 1'b1) $display("[TB] FAIL b2b_ready0: got %b expected 1", upd_ready); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (upd_done !== 1'b1 || upd_ready !== 1'b0 || upd_err !== 1'b0) $display("[TB] FAIL b2b_exec%0d: got done=%b ready=%b err=%b expected 1/0/0", i, upd_done, upd_ready, upd_err); else passes++;
      if (i == 3) upd_valid = 1'b0;
      upd_addr = AW'(11 + i); upd_data = EW'(32'h10B + i);
      @(negedge clk);
      checks++; if (upd_done !== 1'b0 || upd_ready !== 1'b1) $display("[TB] FAIL b2b_idle%0d: got done=%b ready=%b expected 0/1", i, upd_done, upd_ready); else passes++;
    end
    checks++; if (entry_count !== 12'd4) $display("[TB] FAIL b2b_count: got %0d expected 4", entry_count); else passes++;
    do_update(OP_ILL, 11'd20, EW'(32'h1), g, er);
    checks++; if (g !== 1'b1 || er !== 1'b1 || entry_count !== 12'd4) $display("[TB] FAIL op00: got err=%b count=%0d expected 1/4", er, entry_count); else passes++;
    do_update(OP_INS, 11'd1739, EW'(32'h1), g, er);
    checks++; if (g !== 1'b1 || er !== 1'b1 || entry_count !== 12'd4) $display("[TB] FAIL addr_oor: got err=%b count=%0d expected 1/4", er, entry_count); else passes++;
    do_lookup(11'd1739, e, v, h, d);
    checks++; if (v !== 1'b1 || h !== 1'b0 || d !== '0) $display("[TB] FAIL lkp_oor: got v=%b hit=%b data=%h expected 1/0/0", v, h, d); else passes++;
  endtask

  task automatic test_stream;
    logic          exp_hit;
    logic [EW-1:0] exp_data;
    int            idx;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      idx = c - 3;
      if (idx >= 0 && idx < 20) begin
        exp_hit  = (idx >= 10 && idx <= 13);
        exp_data = exp_hit ? EW'(32'h100 + idx) : '0;
        checks++; if (res_valid !== 1'b1 || res_hit !== exp_hit || res_data !== exp_data) $display("[TB] FAIL stream%0d: got v=%b hit=%b data=%h expected 1/%b/%h", idx, res_valid, res_hit, res_data, exp_hit, exp_data); else passes++;
      end else begin
        checks++; if (res_valid !== 1'b0) $display("[TB] FAIL stream_idle%0d: got valid=%b expected 0", c, res_valid); else passes++;
      end
      lkp_valid = (c < 20);
      lkp_addr  = AW'(c);
    end
    lkp_valid = 1'b0;
  endtask

  task automatic test_reset_exec;
    logic e, v, h; logic [EW-1:0] d;
    @(negedge clk); upd_valid = 1'b1; upd_op = OP_INS; upd_addr = 11'd30; upd_data = EW'(32'h3030);
    @(posedge clk); #1 rst_n = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    checks++; if (upd_done !== 1'b0 || upd_err !== 1'b0) $display("[TB] FAIL rst_exec_done: got done=%b err=%b expected 0/0", upd_done, upd_err); else passes++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (upd_done !== 1'b0 || upd_ready !== 1'b1) $display("[TB] FAIL rst_exec_after: got done=%b ready=%b expected 0/1", upd_done, upd_ready); else passes++;
    checks++; if (entry_count !== 12'd0) $display("[TB] FAIL rst_exec_count: got %0d expected 0", entry_count); else passes++;
    do_lookup(11'd30, e, v, h, d);
    checks++; if (v !== 1'b1 || h !== 1'b0 || d !== '0) $display("[TB] FAIL rst_exec_lkp: got v=%b hit=%b data=%h expected 1/0/0", v, h, d); else passes++;
    do_lookup(11'd10, e, v, h, d);
    checks++; if (h !== 1'b0 || d !== '0) $display("[TB] FAIL rst_clears_occ: got hit=%b data=%h expected 0/0", h, d); else passes++;
  endtask

  initial begin
    rst_n = 1'b0; lkp_valid = 1'b0; lkp_addr = '0;
    upd_valid = 1'b0; upd_op = OP_ILL; upd_addr = '0; upd_data = '0;
    test_reset();
    test_insert();
    test_modify_delete();
    test_back_to_back();
    test_stream();
    test_reset_exec();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/smallseg_rule_table.md
SMALLSEG_RULE_TABLE -- requirements
Module: smallseg_rule_table

Interface
REQ-001 Parameter ENTRY_W, default 171, meaning: rule entry width in bits (IP/len, port ranges, protocol, wildcard, ruleID, index).
REQ-002 Parameter DEPTH, default 1739, meaning: number of entries.
REQ-003 Parameter ADDR_W, default 11, meaning: address width; ADDR_W SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 lkp_valid  in  1  lookup request.
REQ-007 lkp_addr  in  ADDR_W  lookup address.
REQ-008 res_valid  out  1  lookup result strobe.
REQ-009 res_hit  out  1  addressed entry is occupied.
REQ-010 res_data  out  ENTRY_W  entry contents, all zero when res_hit=0.
REQ-011 upd_valid  in  1  update request.
REQ-012 upd_ready  out  1  update can be accepted.
REQ-013 upd_op  in  2  01 insert, 10 delete, 11 modify, 00 illegal.
REQ-014 upd_addr  in  ADDR_W  update address.
REQ-015 upd_data  in  ENTRY_W  entry written by insert/modify.
REQ-016 upd_done  out  1  one-cycle completion pulse.
REQ-017 upd_err  out  1  error flag, valid only with upd_done.
REQ-018 entry_count  out  ADDR_W+1  number of occupied entries.

Function
REQ-019 Entry data SHALL be held in a block RAM of DEPTH x ENTRY_W; occupancy SHALL be held in a DEPTH-bit flop vector, cleared by reset.
REQ-020 Lookups SHALL be accepted every cycle lkp_valid=1, with no backpressure; a lookup sampled at edge t SHALL produce res_valid=1 in the cycle after edge t+2 (fixed 2-cycle latency, fully pipelined).
REQ-021 res_hit SHALL equal the occupancy bit; res_data SHALL equal the RAM word when hit, else zero.
REQ-022 lkp_addr >= DEPTH SHALL return res_hit=0, res_data=0.
REQ-023 Update FSM SHALL have states IDLE and EXEC; upd_ready=1 only in IDLE; handshake upd_valid&upd_ready in IDLE latches op/addr/data and moves to EXEC.
REQ-024 EXEC SHALL last one cycle, pulse upd_done with upd_err, perform the write if no error, and return to IDLE; sustained throughput is one update per 2 cycles.
REQ-025 Insert: error if occupied; else write data, set occupancy bit, entry_count+1.
REQ-026 Delete: error if empty; else clear occupancy bit, RAM data untouched, entry_count-1.
REQ-027 Modify: error if empty; else write data, occupancy and count unchanged.
REQ-028 op 00 or upd_addr >= DEPTH SHALL set upd_err=1 with no state change.
REQ-029 Write-first ordering: an EXEC write to address A in the cycle of a lookup's sample edge or the following cycle SHALL be reflected in that lookup's result (data and hit).
REQ-030 upd_done/upd_err SHALL be low in every cycle other than the EXEC cycle.
REQ-031 entry_count SHALL never wrap; its range is 0..DEPTH by construction of REQ-025/026.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: FSM to IDLE, upd_ready=1 after release, upd_done=0, upd_err=0, res_valid=0, res_hit=0, res_data=0, entry_count=0, all occupancy bits 0, lookup pipeline flushed.
REQ-033 Reset during EXEC SHALL abort the update with no write and no upd_done; RAM data is not cleared but is unreachable since all entries read as empty.

Verification
REQ-034 Reset, lookup addr 5 -> res_valid 2 cycles later, res_hit=0, res_data=0, entry_count=0.
REQ-035 Insert addr 5 data 0x1234 -> upd_done with upd_err=0, entry_count=1; lookup addr 5 -> hit=1, data=0x1234; second insert addr 5 -> upd_err=1, count stays 1.
REQ-036 Modify addr 5 to 0xABCD with lookup addr 5 sampled on the EXEC edge -> that result returns 0xABCD; delete addr 5 -> count 0, lookup returns hit=0, data 0; delete again -> upd_err=1.
REQ-037 upd_valid held high with 4 inserts back-to-back -> upd_ready toggles 1/0, one upd_done every 2 cycles, count=4; op 00 and addr 1739 -> upd_err=1, count unchanged.
REQ-038 Lookup every cycle for 20 cycles on addresses 0..19 -> 20 results in order, each exactly 2 cycles after request.
REQ-039 rst_n asserted during EXEC of an insert -> no upd_done; after release, count=0 and lookup of that address returns hit=0.
